// File: rtl/sad_best_match_pkg.sv
// Shared definitions for the SAD pipeline: default datapath widths and the
// best-match tracker state encoding.
package sad_best_match_pkg;

  localparam int DEF_SAD_W = 17;  // sum of eight 14-bit partials
  localparam int DEF_IDX_W = 16;
  localparam int DEF_CNT_W = 17;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } track_state_e;

endpackage

// File: rtl/sad_result_hold.sv
// Valid/ready holding register. A load always wins; loading over an
// unaccepted result raises a sticky overwrite flag.
module sad_result_hold #(
  parameter int W = 50
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         overrun_o
);

  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    data_d    = data_q;
    if (load_i) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
      // A coincident handshake means the old result was taken, so no overrun.
      if (valid_q && !ready_i) overrun_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sad_best_match.sv
// Tracks the minimum-SAD candidate of each search and publishes the winner
// through a valid/ready port, decoupled so the next search never stalls.
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W = DEF_SAD_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [IDX_W-1:0] In_Index,
  input  logic [SAD_W-1:0] In_SAD,
  input  logic             In_Last,
  output logic             Best_Valid,
  input  logic             Best_Ready,
  output logic [IDX_W-1:0] Best_Index,
  output logic [SAD_W-1:0] Best_SAD,
  output logic [CNT_W-1:0] Best_Count,
  output logic             Busy,
  output logic             Overrun
);

  localparam int RES_W = IDX_W + SAD_W + CNT_W;

  track_state_e     state_q, state_d;
  logic [SAD_W-1:0] min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             publish;
  logic [RES_W-1:0] res_data;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    if (In_Valid) begin
      if (state_q == ST_IDLE) begin
        min_d   = In_SAD;
        idx_d   = In_Index;
        cnt_d   = CNT_W'(1);
        state_d = ST_TRACK;
      end else begin
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        // Strict compare: ties keep the earlier candidate.
        if (In_SAD < min_q) begin
          min_d = In_SAD;
          idx_d = In_Index;
        end
      end
      if (In_Last) begin
        publish = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  sad_result_hold #(
    .W(RES_W)
  ) u_hold (
    .clk        (clk),
    .rst_i      (Reset),
    .load_i     (publish),
    .load_data_i({idx_d, min_d, cnt_d}),
    .ready_i    (Best_Ready),
    .valid_o    (Best_Valid),
    .data_o     (res_data),
    .overrun_o  (Overrun)
  );

  assign {Best_Index, Best_SAD, Best_Count} = res_data;
  assign Busy = (state_q == ST_TRACK);

endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench for sad_best_match: hand-computed expectations for each
// search scenario, all checks routed through one comparison task.
module tb_sad_best_match;

  logic        clk;
  logic        Reset;
  logic        In_Valid;
  logic [15:0] In_Index;
  logic [16:0] In_SAD;
  logic        In_Last;
  logic        Best_Valid;
  logic        Best_Ready;
  logic [15:0] Best_Index;
  logic [16:0] Best_SAD;
  logic [16:0] Best_Count;
  logic        Busy;
  logic        Overrun;

  int n_cmp = 0;
  int n_err = 0;

  sad_best_match dut (
    .clk       (clk),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Index  (In_Index),
    .In_SAD    (In_SAD),
    .In_Last   (In_Last),
    .Best_Valid(Best_Valid),
    .Best_Ready(Best_Ready),
    .Best_Index(Best_Index),
    .Best_SAD  (Best_SAD),
    .Best_Count(Best_Count),
    .Busy      (Busy),
    .Overrun   (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end else begin
      $display("  ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Present one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic drive(input logic v, input logic [15:0] idx, input logic [16:0] sad,
                       input logic last, input logic rdy);
    In_Valid   = v;
    In_Index   = idx;
    In_SAD     = sad;
    In_Last    = last;
    Best_Ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] idx,
                              input logic [16:0] sad, input logic [16:0] cnt);
    check({tag, ".valid"}, 32'(Best_Valid), 32'd1);
    check({tag, ".index"}, 32'(Best_Index), 32'(idx));
    check({tag, ".sad"},   32'(Best_SAD),   32'(sad));
    check({tag, ".count"}, 32'(Best_Count), 32'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},   32'(Best_Valid), 32'd0);
    check({tag, ".index"},   32'(Best_Index), 32'd0);
    check({tag, ".sad"},     32'(Best_SAD),   32'd0);
    check({tag, ".count"},   32'(Best_Count), 32'd0);
    check({tag, ".busy"},    32'(Busy),       32'd0);
    check({tag, ".overrun"}, 32'(Overrun),    32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    In_Valid = 1'b0; In_Index = '0; In_SAD = '0; In_Last = 1'b0; Best_Ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    Reset = 1'b0;

    // Single search with a tie: 500,120,300,120 -> index 1 wins.
    drive(1, 16'd0, 17'd500, 0, 0);
    check("s1.busy_after_first", 32'(Busy), 32'd1);
    drive(1, 16'd1, 17'd120, 0, 0);
    drive(1, 16'd2, 17'd300, 0, 0);
    check("s1.valid_before_last", 32'(Best_Valid), 32'd0);
    drive(1, 16'd3, 17'd120, 1, 0);
    check_result("s1", 16'd1, 17'd120, 17'd4);
    check("s1.busy_done", 32'(Busy), 32'd0);
    drive(0, 16'd0, 17'd0, 0, 1);
    check("s1.valid_after_hs", 32'(Best_Valid), 32'd0);
    check("s1.overrun", 32'(Overrun), 32'd0);

    // One-candidate search at full-scale SAD; left pending.
    drive(1, 16'h00FF, 17'h1FFFF, 1, 0);
    check("s2.busy", 32'(Busy), 32'd0);
    check_result("s2", 16'h00FF, 17'h1FFFF, 17'd1);

    // Coincident publish and handshake: new result, no overrun.
    drive(1, 16'd4, 17'd40, 0, 0);
    check("s3.hold_index", 32'(Best_Index), 32'h00FF);
    drive(1, 16'd5, 17'd30, 1, 1);
    check_result("s3", 16'd5, 17'd30, 17'd2);
    check("s3.overrun", 32'(Overrun), 32'd0);
    drive(0, 16'd0, 17'd0, 0, 1);
    check("s3.valid_after_hs", 32'(Best_Valid), 32'd0);

    // Back-pressure: pending result overwritten by a second search.
    drive(1, 16'd6, 17'd100, 1, 0);
    check_result("s4a", 16'd6, 17'd100, 17'd1);
    drive(1, 16'd8, 17'd20, 0, 0);
    drive(1, 16'd9, 17'd7, 0, 0);
    check("s4.hold_sad", 32'(Best_SAD), 32'd100);
    drive(1, 16'd10, 17'd7, 1, 0);
    check_result("s4b", 16'd9, 17'd7, 17'd3);
    check("s4.overrun", 32'(Overrun), 32'd1);
    drive(0, 16'd0, 17'd0, 0, 0);
    check("s4.still_valid", 32'(Best_Valid), 32'd1);
    check("s4.overrun_sticky", 32'(Overrun), 32'd1);
    drive(0, 16'd0, 17'd0, 0, 1);
    check("s4.valid_after_hs", 32'(Best_Valid), 32'd0);
    check("s4.overrun_after_hs", 32'(Overrun), 32'd1);

    // Input gaps, plus an In_Last with In_Valid low that must be ignored.
    drive(1, 16'd11, 17'd60, 0, 0);
    drive(0, 16'd99, 17'd1, 1, 0);
    check("s5.busy_gap", 32'(Busy), 32'd1);
    check("s5.no_publish", 32'(Best_Valid), 32'd0);
    drive(1, 16'd12, 17'd25, 0, 0);
    drive(0, 16'd0, 17'd0, 0, 0);
    drive(1, 16'd13, 17'd40, 1, 0);
    check_result("s5", 16'd12, 17'd25, 17'd3);

    // Asynchronous reset mid-search, then a clean one-candidate search.
    drive(0, 16'd0, 17'd0, 0, 1);
    drive(1, 16'd20, 17'd5, 0, 0);
    drive(1, 16'd21, 17'd3, 0, 0);
    check("s6.busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check_all_zero("s6.async_reset");
    In_Valid = 1'b0; In_Last = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    drive(1, 16'd22, 17'd50, 1, 0);
    check_result("s6", 16'd22, 17'd50, 17'd1);
    check("s6.overrun", 32'(Overrun), 32'd0);
    check("s6.busy", 32'(Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
